// File: rtl/pipeline_credit_drain.sv
// rtl/pipeline_credit_drain.sv - credit-throttled issue into a valid-only pipeline with a result FIFO
// Optional latency checker: PIPE_DRAIN_LATENCY_CHECK_EN
module pipeline_credit_drain #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       pipe_valid,
    output logic [WIDTH-1:0]           pipe_data,
    input  logic                       pipe_res_valid,
    input  logic [WIDTH-1:0]           pipe_res_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] credits,
    output logic                       err_overflow,
    output logic                       err_latency
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    if (LATENCY < 1 || DEPTH < 1) begin : g_param_check
        $error("pipeline_credit_drain: LATENCY and DEPTH must be >= 1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    credit_q;
    logic             pop;
    logic             wr_en;
    logic             drop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign in_ready   = (credit_q != '0);
    assign pipe_valid = in_valid & in_ready;
    assign pipe_data  = in_data;
    assign credits    = credit_q;

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign pop   = out_valid & out_ready;
    assign wr_en = pipe_res_valid & ((count != FULL) | pop);
    assign drop  = pipe_res_valid & (count == FULL) & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= pipe_res_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            credit_q     <= FULL;
            err_overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Saturate so a spurious result cannot push credits above DEPTH.
            case ({pipe_valid, pop})
                2'b10:   credit_q <= credit_q - CW'(1);
                2'b01:   credit_q <= (credit_q == FULL) ? credit_q : credit_q + CW'(1);
                default: credit_q <= credit_q;
            endcase
            if (drop) begin
                err_overflow <= 1'b1;
            end
        end
    end

`ifdef PIPE_DRAIN_LATENCY_CHECK_EN
    logic [LATENCY-1:0] shadow;
    logic [LATENCY-1:0] shadow_nxt;
    logic               lat_err_q;

    always_comb begin
        shadow_nxt    = shadow << 1;
        shadow_nxt[0] = pipe_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            lat_err_q <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            if (shadow[LATENCY-1] != pipe_res_valid) begin
                lat_err_q <= 1'b1;
            end
        end
    end

    assign err_latency = lat_err_q;
`else
    assign err_latency = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_credit_drain.sv
// tb/tb_pipeline_credit_drain.sv - scoreboard bench for pipeline_credit_drain with a 2-stage +1 pipeline model
module tb_pipeline_credit_drain;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, pipe_valid, pipe_res_valid;
    logic        out_valid, out_ready, err_overflow, err_latency;
    logic [31:0] in_data, pipe_data, pipe_res_data, out_data;
    logic [2:0]  credits;
    logic        inj;
    logic        s1_v, s2_v;
    logic [31:0] s1_d, s2_d;

    int          checks = 0;
    int          failures = 0;
    int          pops = 0;
    logic [31:0] q[$];
    logic        lat_exp;

    always #5 clk = ~clk;

    pipeline_credit_drain #(.WIDTH(32), .LATENCY(2), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pipe_valid(pipe_valid), .pipe_data(pipe_data),
        .pipe_res_valid(pipe_res_valid), .pipe_res_data(pipe_res_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .credits(credits), .err_overflow(err_overflow), .err_latency(err_latency)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s1_d <= '0;
            s2_d <= '0;
        end else begin
            s1_v <= pipe_valid;
            s1_d <= pipe_data + 32'd1;
            s2_v <= s1_v;
            s2_d <= s1_d;
        end
    end

    assign pipe_res_valid = s2_v | inj;
    assign pipe_res_data  = inj ? 32'hDEAD_BEEF : s2_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [31:0] e;
        @(negedge clk);
        if (pipe_valid) q.push_back(in_data + 32'd1);
        if (out_valid && out_ready) begin
            pops++;
            if (q.size() == 0) begin
                check("unexpected_output", {31'd0, out_valid}, 32'd0);
            end else begin
                e = q.pop_front();
                check("sb_data", out_data, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nd;
        int first_block;
        int vcnt;
        logic issued;
`ifdef PIPE_DRAIN_LATENCY_CHECK_EN
        lat_exp = 1'b1;
`else
        lat_exp = 1'b0;
`endif
        in_valid = 0; in_data = 0; out_ready = 0; inj = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_credits", 32'(credits), 32'd4);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_err_overflow", 32'(err_overflow), 32'd0);
        check("rst_err_latency", 32'(err_latency), 32'd0);

        // Single transaction
        in_valid = 1; in_data = 32'h10; out_ready = 1;
        cycle();
        in_valid = 0;
        for (int k = 1; k <= 3; k++) begin
            check("single_credits", 32'(credits), 32'd3);
            check("single_out_valid", 32'(out_valid), (k == 3) ? 32'd1 : 32'd0);
            cycle();
        end
        check("single_credits_after_pop", 32'(credits), 32'd4);
        check("single_pops", 32'(pops), 32'd1);

        // Stall fill
        out_ready = 0; in_valid = 1; nd = 1; first_block = -1;
        for (int c = 0; c < 8; c++) begin
            in_data = 32'(nd);
            if (!in_ready && first_block < 0) first_block = c;
            issued = in_ready;
            cycle();
            if (issued) nd++;
        end
        check("fill_block_cycle", 32'(first_block), 32'd4);
        check("fill_issued", 32'(nd - 1), 32'd4);
        check("fill_sb_depth", 32'(q.size()), 32'd4);
        check("fill_head", out_data, 32'd2);
        check("fill_err_overflow", 32'(err_overflow), 32'd0);
        check("fill_err_latency", 32'(err_latency), 32'd0);

        // Fault injection: spurious result into a full FIFO
        in_valid = 0; inj = 1;
        cycle();
        inj = 0;
        check("fault_err_overflow", 32'(err_overflow), 32'd1);
        check("fault_head", out_data, 32'd2);
        check("fault_err_latency", 32'(err_latency), 32'(lat_exp));
        check("fault_credits", 32'(credits), 32'd0);

        // Drain and wrap, finishing inputs 5 and 6
        out_ready = 1; pops = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 0) check("drain_in_ready_c0", 32'(in_ready), 32'd0);
            if (c == 1) check("drain_in_ready_c1", 32'(in_ready), 32'd1);
            in_valid = (nd <= 6);
            in_data  = 32'(nd);
            issued   = in_valid && in_ready;
            cycle();
            if (issued) nd++;
        end
        in_valid = 0;
        check("drain_pops", 32'(pops), 32'd6);
        check("drain_sb_empty", 32'(q.size()), 32'd0);
        check("drain_credits", 32'(credits), 32'd4);
        check("drain_err_overflow_sticky", 32'(err_overflow), 32'd1);

        // Streaming
        pops = 0; in_valid = 1; out_ready = 1;
        for (int c = 0; c < 20; c++) begin
            in_data = 32'h100 + 32'(c);
            cycle();
        end
        check("stream_credits", 32'(credits), 32'd1);
        check("stream_pops", 32'(pops), 32'd17);
        in_valid = 0;
        repeat (5) cycle();
        check("stream_total_pops", 32'(pops), 32'd20);
        check("stream_sb_empty", 32'(q.size()), 32'd0);

        // Async reset with 2 queued and 2 in flight
        out_ready = 0; in_valid = 1;
        for (int c = 0; c < 4; c++) begin
            in_data = 32'h200 + 32'(c);
            cycle();
        end
        in_valid = 0;
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        check("pre_rst_credits", 32'(credits), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_credits", 32'(credits), 32'd4);
        check("rst_mid_err_overflow", 32'(err_overflow), 32'd0);
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1; pops = 0; vcnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) vcnt++;
            cycle();
        end
        check("post_rst_no_stale", 32'(vcnt), 32'd0);
        check("post_rst_pops", 32'(pops), 32'd0);
        check("post_rst_credits", 32'(credits), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
